// File: rtl/screen_draw_sequencer_pkg.sv
// Shared types and constants for the screen draw sequencer: FSM encoding,
// width helpers and the screen index map used by game control and the ROM mux.
package screen_draw_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SCR_SAVE_GPA    = 0;
   localparam int SCR_START       = 1;
   localparam int SCR_STAGE_START = 2;
   localparam int SCR_STAGE_CLEAR = 3;
   localparam int SCR_BOSS_START  = 4;
   localparam int SCR_BOSS_CLEAR  = 5;
   localparam int SCR_PAUSE       = 6;
   localparam int SCR_WIN         = 7;
   localparam int SCR_LOSE        = 8;

   function automatic int addr_width(input int w, input int h);
      return $clog2(w * h);
   endfunction

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/screen_draw_sequencer_scan.sv
// Raster position generator: row-major x/y walk with a linear pixel index
// and a flag marking the final pixel of the frame.
module pixel_scan_counter
   import screen_draw_sequencer_pkg::*;
#(
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int SCR_W  = 160,
   parameter int SCR_H  = 120,
   parameter int ADDR_W = addr_width(SCR_W, SCR_H)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear,
   input  logic              advance,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic x_end;

   assign x_end = (x == X_W'(SCR_W - 1));
   assign last  = x_end && (y == Y_W'(SCR_H - 1));

   // Index tracks y*SCR_W+x incrementally so no multiplier is needed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (advance) begin
         addr <= last ? '0 : addr + ADDR_W'(1);
         if (x_end) begin
            x <= '0;
            y <= last ? '0 : y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end
   end

endmodule

// File: rtl/screen_draw_sequencer.sv
// Shared pixel scanner for all game screens: arbitrates requests, fetches
// pixels from the screen ROM and feeds colour/coordinates/plot to the VGA adapter.
//
// state | meaning
// IDLE  | waiting for a request, lowest index granted
// SCAN  | issuing one ROM address per cycle
// DRAIN | all addresses issued, waiting for ROM pipeline to empty
// DONE  | done[sel] high until req[sel] drops
module screen_draw_sequencer
   import screen_draw_sequencer_pkg::*;
#(
   parameter  int NUM_SCREENS = 9,
   parameter  int COLOUR_W    = 9,
   parameter  int X_W         = 8,
   parameter  int Y_W         = 7,
   parameter  int SCR_W       = 160,
   parameter  int SCR_H       = 120,
   parameter  int ROM_LAT     = 1,
   localparam int ADDR_W      = addr_width(SCR_W, SCR_H),
   localparam int SEL_W       = sel_width(NUM_SCREENS)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_SCREENS-1:0] req,
   output logic [ADDR_W-1:0]      rom_addr,
   output logic [SEL_W-1:0]       rom_sel,
   input  logic [COLOUR_W-1:0]    rom_data,
   output logic [COLOUR_W-1:0]    colour,
   output logic [X_W+Y_W-1:0]     coordinates,
   output logic                   plot,
   output logic [NUM_SCREENS-1:0] done,
   output logic                   busy
);

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  sel, grant_idx;
   logic              grant_any, abort, issue, pipe_empty;
   logic [X_W-1:0]    cnt_x;
   logic [Y_W-1:0]    cnt_y;
   logic [ADDR_W-1:0] cnt_addr;
   logic              cnt_last;

   logic [ROM_LAT:0]  vld_pipe;
   logic [X_W-1:0]    x_pipe [ROM_LAT+1];
   logic [Y_W-1:0]    y_pipe [ROM_LAT+1];

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = NUM_SCREENS - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant_any = 1'b1;
            grant_idx = SEL_W'(i);
         end
      end
   end

   assign abort      = ((state == SCAN) || (state == DRAIN)) && !req[sel];
   assign issue      = (state == SCAN) && !abort;
   assign pipe_empty = ~|vld_pipe;

   pixel_scan_counter #(
      .X_W    (X_W),
      .Y_W    (Y_W),
      .SCR_W  (SCR_W),
      .SCR_H  (SCR_H),
      .ADDR_W (ADDR_W)
   ) u_scan (
      .clk     (clk),
      .resetn  (resetn),
      .clear   ((state == IDLE) && grant_any),
      .advance (issue),
      .x       (cnt_x),
      .y       (cnt_y),
      .addr    (cnt_addr),
      .last    (cnt_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         sel   <= '0;
      end else begin
         state <= state_nxt;
         if ((state == IDLE) && grant_any) sel <= grant_idx;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = SCAN;
         SCAN:    if (abort) state_nxt = IDLE;
                  else if (cnt_last) state_nxt = DRAIN;
         DRAIN:   if (abort) state_nxt = IDLE;
                  else if (pipe_empty) state_nxt = DONE;
         DONE:    if (!req[sel]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SCAN) || (state == DRAIN);
      done = '0;
      if (state == DONE) done[sel] = 1'b1;
   end

   // Stage 0 lines up with rom_addr, stage ROM_LAT with the matching rom_data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_pipe <= '0;
         for (int i = 0; i <= ROM_LAT; i++) begin
            x_pipe[i] <= '0;
            y_pipe[i] <= '0;
         end
      end else begin
         vld_pipe[0] <= issue;
         x_pipe[0]   <= cnt_x;
         y_pipe[0]   <= cnt_y;
         for (int i = 1; i <= ROM_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            x_pipe[i]   <= x_pipe[i-1];
            y_pipe[i]   <= y_pipe[i-1];
         end
         if (abort) vld_pipe <= '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rom_addr    <= '0;
         rom_sel     <= '0;
         colour      <= '0;
         coordinates <= '0;
         plot        <= 1'b0;
      end else begin
         if (issue) begin
            rom_addr <= cnt_addr;
            rom_sel  <= sel;
         end
         plot <= vld_pipe[ROM_LAT] && !abort;
         if (vld_pipe[ROM_LAT] && !abort) begin
            colour      <= rom_data;
            coordinates <= {x_pipe[ROM_LAT], y_pipe[ROM_LAT]};
         end
      end
   end

endmodule

// File: tb/tb_screen_draw_sequencer.sv
// Directed bench: a 4x2 instance with two-cycle ROM for sequencing detail and
// a full 160x120 instance for raster wrap, each with its own ROM model.
module tb_screen_draw_sequencer;
   import screen_draw_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   int          errors = 0;
   int          checks = 0;

   logic [8:0]  req_s = '0, done_s, colour_s, rom_data_s, d1_s, d2_s;
   logic [2:0]  rom_addr_s;
   logic [3:0]  rom_sel_s;
   logic [14:0] coord_s;
   logic        plot_s, busy_s;

   logic [8:0]  req_w = '0, done_w, colour_w, rom_data_w;
   logic [14:0] rom_addr_w;
   logic [3:0]  rom_sel_w;
   logic [14:0] coord_w;
   logic        plot_w, busy_w;

   always #5 clk = ~clk;

   screen_draw_sequencer #(.SCR_W(4), .SCR_H(2), .ROM_LAT(2)) dut_s (
      .clk(clk), .resetn(resetn), .req(req_s), .rom_addr(rom_addr_s),
      .rom_sel(rom_sel_s), .rom_data(rom_data_s), .colour(colour_s),
      .coordinates(coord_s), .plot(plot_s), .done(done_s), .busy(busy_s));

   screen_draw_sequencer #(.SCR_W(160), .SCR_H(120), .ROM_LAT(1)) dut_w (
      .clk(clk), .resetn(resetn), .req(req_w), .rom_addr(rom_addr_w),
      .rom_sel(rom_sel_w), .rom_data(rom_data_w), .colour(colour_w),
      .coordinates(coord_w), .plot(plot_w), .done(done_w), .busy(busy_w));

   function automatic logic [8:0] rom_fn(input logic [3:0] s, input logic [14:0] a);
      return a[8:0] ^ {s, 5'h15};
   endfunction

   always @(posedge clk) begin
      d1_s       <= rom_fn(rom_sel_s, {12'd0, rom_addr_s});
      d2_s       <= d1_s;
      rom_data_w <= rom_fn(rom_sel_w, rom_addr_w);
   end
   assign rom_data_s = d2_s;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int          nplots;
   logic [14:0] last_coord;
   logic [8:0]  last_col;
   logic        x_ovf;

   initial begin
      // reset with every request high
      req_s = '1;
      req_w = '1;
      repeat (3) tick();
      check("rst_addr", rom_addr_s, 0);
      check("rst_sel", rom_sel_s, 0);
      check("rst_colour", colour_s, 0);
      check("rst_coord", coord_s, 0);
      check("rst_plot", plot_s, 0);
      check("rst_done", done_s, 0);
      check("rst_busy", busy_s, 0);
      check("rst_plot_w", plot_w, 0);
      req_s = '0;
      req_w = '0;
      tick();
      resetn = 1'b1;
      repeat (2) tick();
      check("idle_busy", busy_s, 0);
      check("idle_done", done_s, 0);

      // single screen, request raised before edge 0
      req_s = 9'(1 << SCR_STAGE_START);
      for (int c = 0; c <= 13; c++) begin
         tick();
         if (c >= 1 && c <= 8) begin
            check("one_addr", rom_addr_s, c - 1);
            check("one_sel", rom_sel_s, SCR_STAGE_START);
         end
         check("one_plot", plot_s, (c >= 4 && c <= 11));
         if (c >= 4 && c <= 11) begin
            check("one_coord", coord_s, {8'((c - 4) % 4), 7'((c - 4) / 4)});
            check("one_colour", colour_s, rom_fn(4'd2, 15'(c - 4)));
         end
         check("one_done", done_s, (c >= 12) ? 9'h004 : 9'h000);
         check("one_busy", busy_s, (c <= 11));
      end
      req_s = '0;
      tick();
      check("one_done_clr", done_s, 0);
      check("one_idle", busy_s, 0);

      // priority: 0 and 5 together
      req_s = 9'h021;
      tick();
      tick();
      check("pri_sel0", rom_sel_s, 0);
      for (int n = 0; n < 40 && done_s == 9'h000; n++) tick();
      check("pri_done0", done_s, 9'h001);
      req_s = 9'h020;
      tick();
      check("pri_done0_clr", done_s, 0);
      check("pri_idle", busy_s, 0);
      tick();
      check("pri_busy5", busy_s, 1);
      tick();
      check("pri_sel5", rom_sel_s, 5);
      for (int n = 0; n < 40 && done_s == 9'h000; n++) tick();
      check("pri_done5", done_s, 9'h020);
      req_s = '0;
      tick();

      // abort after three addresses
      req_s = 9'h008;
      repeat (4) tick();
      check("abt_addr", rom_addr_s, 2);
      req_s = '0;
      tick();
      check("abt_plot", plot_s, 0);
      check("abt_busy", busy_s, 0);
      for (int n = 0; n < 8; n++) begin
         tick();
         check("abt_plot_hold", plot_s, 0);
         check("abt_done", done_s, 0);
      end

      // reset in DRAIN, then a fresh request
      req_s = 9'h002;
      repeat (10) tick();
      check("drn_plot", plot_s, 1);
      check("drn_busy", busy_s, 1);
      resetn = 1'b0;
      #1;
      check("drn_rst_plot", plot_s, 0);
      check("drn_rst_done", done_s, 0);
      check("drn_rst_busy", busy_s, 0);
      req_s = '0;
      tick();
      resetn = 1'b1;
      tick();
      req_s = 9'h002;
      for (int c = 0; c <= 4; c++) begin
         tick();
         if (c == 2) check("fresh_addr", rom_addr_s, 1);
         if (c == 4) begin
            check("fresh_plot", plot_s, 1);
            check("fresh_coord", coord_s, 0);
            check("fresh_colour", colour_s, rom_fn(4'd1, 15'd0));
         end
      end
      for (int n = 0; n < 40 && done_s == 9'h000; n++) tick();
      check("fresh_done", done_s, 9'h002);
      req_s = '0;
      tick();

      // full 160x120 frame
      nplots = 0;
      last_coord = '0;
      last_col = '0;
      x_ovf = 1'b0;
      req_w = 9'(1 << SCR_LOSE);
      for (int n = 0; n < 19400 && done_w == 9'h000; n++) begin
         tick();
         if (plot_w) begin
            nplots++;
            last_coord = coord_w;
            last_col = colour_w;
            if (coord_w[14:7] >= 8'd160) x_ovf = 1'b1;
         end
      end
      check("wrap_done", done_w, 9'h100);
      check("wrap_count", nplots, 19200);
      check("wrap_last_coord", last_coord, {8'd159, 7'd119});
      check("wrap_last_addr", rom_addr_w, 19199);
      check("wrap_last_colour", last_col, rom_fn(4'd8, 15'd19199));
      check("wrap_x_ovf", x_ovf, 0);
      req_w = '0;
      tick();
      check("wrap_done_clr", done_w, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
